// File: rtl/tile_fetch_pipe_if.sv
// Request, BRAM and output bus of the tile fetch pipeline.
// The slave modport is the pipeline's view; the master modport is the
// view of whatever drives requests, models the BRAMs and drains output.
interface tile_fetch_pipe_if #(
  parameter int BPP   = 4,
  parameter int PAL_W = 5,
  parameter int TM_AW = 10,
  parameter int TB_AW = 14,
  parameter int LBX_W = 12
);
  localparam int NPIX = 16 / BPP;
  localparam int LW   = PAL_W + BPP;

  logic                 in_valid;
  logic                 in_ready;
  logic [10:0]          in_sprite_x;
  logic [LBX_W-1:0]     in_lb_x;
  logic [TM_AW-1:0]     in_tm_base;
  logic [TB_AW-1:0]     in_tb_base;
  logic [TM_AW-1:0]     tm_addr;
  logic                 tm_re;
  logic [15:0]          tm_data;
  logic [TB_AW-1:0]     tb_addr;
  logic                 tb_re;
  logic [15:0]          tb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NPIX*LW-1:0]   out_pixels;
  logic [NPIX-1:0]      out_mask;
  logic [LBX_W-1:0]     out_lb_x;

  modport slave (
    input  in_valid, in_sprite_x, in_lb_x, in_tm_base, in_tb_base,
    output in_ready,
    output tm_addr, tm_re,
    input  tm_data,
    output tb_addr, tb_re,
    input  tb_data,
    output out_valid, out_pixels, out_mask, out_lb_x,
    input  out_ready
  );

  modport master (
    output in_valid, in_sprite_x, in_lb_x, in_tm_base, in_tb_base,
    input  in_ready,
    input  tm_addr, tm_re,
    output tm_data,
    input  tb_addr, tb_re,
    output tb_data,
    input  out_valid, out_pixels, out_mask, out_lb_x,
    output out_ready
  );
endinterface

// File: rtl/tile_fetch_pipe.sv
// Three-stage tile fetch pipeline: S1 issues the tilemap read, S2 issues
// the tile bitmap read, S3 registers the unpacked pixel lanes.
// Optional feature: define TILE_HFLIP_EN to honour the tilemap hflip bit
// (word index and lane order mirrored); without it that bit is ignored.
module tile_fetch_pipe #(
  parameter int BPP   = 4,
  parameter int PAL_W = 5,
  parameter int TM_AW = 10,
  parameter int TB_AW = 14,
  parameter int LBX_W = 12
) (
  input  logic             clk_draw,
  input  logic             rst_draw,
  input  logic             flush,
  tile_fetch_pipe_if.slave bus
);
  localparam int NPIX = 16 / BPP;
  localparam int LW   = PAL_W + BPP;
  // log2 of words per tile row: 8 pixels wide is 2 words at 4bpp, 4 at 8bpp
  localparam int WL   = (BPP == 8) ? 2 : 1;

  logic               stall;
  logic               accept;
  logic               s1_valid, s2_valid, s3_valid;
  logic [WL-1:0]      s1_w;
  logic [LBX_W-1:0]   s1_lb_x, s2_lb_x, s3_lb_x;
  logic [TB_AW-1:0]   s1_tb_base;
  logic [PAL_W-1:0]   s2_pal;
  logic [NPIX*LW-1:0] s3_pixels;
  logic [NPIX-1:0]    s3_mask;
  logic [10:0]        word_idx;
  logic [15:0]        pal_ext;
  logic [WL-1:0]      w_eff;
  logic [NPIX-1:0][BPP-1:0] pix;
  logic [NPIX*LW-1:0] lanes;
  logic [NPIX-1:0]    lane_nz;
  logic               unused_bits;

  // A held output freezes every stage, including both BRAM data outputs
  assign stall        = s3_valid && !bus.out_ready;
  assign bus.in_ready = !rst_draw && !stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.tm_re    = !rst_draw && !stall;
  assign bus.tb_re    = !rst_draw && !stall;

  assign word_idx     = bus.in_sprite_x >> WL;
  assign bus.tm_addr  = bus.in_tm_base + TM_AW'(word_idx);
  assign pal_ext      = {11'b0, bus.tm_data[14:10]};

`ifdef TILE_HFLIP_EN
  logic s2_flip;
  // WPT is a power of two, so WPT-1-w is simply the bitwise inverse of w
  assign w_eff = bus.tm_data[15] ? ~s1_w : s1_w;
`else
  assign w_eff = s1_w;
`endif

  assign bus.tb_addr  = s1_tb_base + TB_AW'({bus.tm_data[9:0], w_eff});

  // Split the tile word into lanes, lane 0 being the leftmost pixel
  always_comb begin
    pix     = '0;
    lanes   = '0;
    lane_nz = '0;
    for (int k = 0; k < NPIX; k++) begin
      pix[k] = bus.tb_data[15-k*BPP -: BPP];
`ifdef TILE_HFLIP_EN
      if (s2_flip) pix[k] = bus.tb_data[(k+1)*BPP-1 -: BPP];
`endif
      lanes[k*LW +: LW] = {s2_pal, pix[k]};
      lane_nz[k]        = |pix[k];
    end
  end

  // Stage valid bits and output register; reset and flush drop everything
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s3_pixels <= '0;
      s3_mask   <= '0;
      s3_lb_x   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s3_mask   <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      s3_mask   <= s2_valid ? lane_nz : '0;
      if (s2_valid) begin
        s3_pixels <= lanes;
        s3_lb_x   <= s2_lb_x;
      end
    end
  end

  // Sideband follows its stage; stale contents are harmless once valid drops
  always_ff @(posedge clk_draw) begin
    if (!stall) begin
      s1_w       <= bus.in_sprite_x[WL-1:0];
      s1_lb_x    <= bus.in_lb_x;
      s1_tb_base <= bus.in_tb_base;
      s2_lb_x    <= s1_lb_x;
      s2_pal     <= pal_ext[PAL_W-1:0];
`ifdef TILE_HFLIP_EN
      s2_flip    <= bus.tm_data[15];
`endif
    end
  end

  assign bus.out_valid  = s3_valid;
  assign bus.out_pixels = s3_pixels;
  assign bus.out_mask   = s3_mask;
  assign bus.out_lb_x   = s3_lb_x;

  assign unused_bits = ^{word_idx, pal_ext, bus.tm_data[15]};
endmodule

// File: tb/tb_tile_fetch_pipe.sv
// Bench for tile_fetch_pipe: a 4bpp instance exercised with directed and
// random traffic against a scoreboard, plus an 8bpp instance for the
// address wrap case. Expectations follow TILE_HFLIP_EN when it is defined.
module tb_tile_fetch_pipe;
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] pix;
    logic [7:0]  mask;
    logic [11:0] lbx;
  } exp_t;

  exp_t q[$];
  logic [15:0] tmap [1024];
  logic [15:0] tile [16384];

  always #5 clk = ~clk;

  tile_fetch_pipe_if #(.BPP(4)) bus4 ();
  tile_fetch_pipe_if #(.BPP(8)) bus8 ();

  tile_fetch_pipe #(.BPP(4)) u4 (.clk_draw(clk), .rst_draw(rst), .flush(flush), .bus(bus4));
  tile_fetch_pipe #(.BPP(8)) u8 (.clk_draw(clk), .rst_draw(rst), .flush(flush), .bus(bus8));

  // One-cycle BRAMs that hold their output while not enabled
  always @(posedge clk) begin
    if (bus4.tm_re) bus4.tm_data <= tmap[bus4.tm_addr];
    if (bus4.tb_re) bus4.tb_data <= tile[bus4.tb_addr];
    if (bus8.tm_re) bus8.tm_data <= tmap[bus8.tm_addr];
    if (bus8.tb_re) bus8.tb_data <= tile[bus8.tb_addr];
  end

  // Expected group for one request, computed arithmetically from the memories
  function automatic exp_t model(int bpp, int sx, int lbx, int tmb, int tbb);
    exp_t e;
    int wpt, npix, lw, ent, tidx, pal, w, word, p;
    bit flip;
    wpt  = bpp / 2;
    npix = 16 / bpp;
    lw   = 5 + bpp;
    ent  = int'(tmap[(tmb + sx / wpt) % 1024]);
    tidx = ent % 1024;
    pal  = (ent / 1024) % 32;
    flip = 1'b0;
`ifdef TILE_HFLIP_EN
    flip = (ent >= 32768);
`endif
    w = sx % wpt;
    if (flip) w = wpt - 1 - w;
    word  = int'(tile[(tbb + tidx * wpt + w) % 16384]);
    e.pix  = '0;
    e.mask = '0;
    e.lbx  = 12'(lbx);
    for (int k = 0; k < npix; k++) begin
      if (flip) p = (word >> (k * bpp)) % (1 << bpp);
      else      p = (word >> (16 - (k + 1) * bpp)) % (1 << bpp);
      e.pix     = e.pix | (64'(pal * (1 << bpp) + p) << (k * lw));
      e.mask[k] = (p != 0);
    end
    return e;
  endfunction

  // Scoreboard: every presented group must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (q.size() == 0) begin
        checks++;
        assert (bus4.out_valid === 1'b0) else begin
          errors++;
          $error("[TB] FAIL unexpected_group got out_valid=%0b expected 0", bus4.out_valid);
        end
      end else if (bus4.out_valid === 1'b1) begin
        checks++;
        assert ({28'b0, bus4.out_pixels} === q[0].pix) else begin
          errors++;
          $error("[TB] FAIL sb_pixels got %0h expected %0h", bus4.out_pixels, q[0].pix);
        end
        checks++;
        assert ({4'b0, bus4.out_mask} === q[0].mask) else begin
          errors++;
          $error("[TB] FAIL sb_mask got %0h expected %0h", bus4.out_mask, q[0].mask);
        end
        checks++;
        assert (bus4.out_lb_x === q[0].lbx) else begin
          errors++;
          $error("[TB] FAIL sb_lb_x got %0h expected %0h", bus4.out_lb_x, q[0].lbx);
        end
        if (bus4.out_ready) void'(q.pop_front());
      end
      if (bus4.in_valid && bus4.in_ready)
        q.push_back(model(4, int'(bus4.in_sprite_x), int'(bus4.in_lb_x),
                          int'(bus4.in_tm_base), int'(bus4.in_tb_base)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int sx, input int lbx, input int tmb, input int tbb);
    bus4.in_valid    = v;
    bus4.in_sprite_x = 11'(sx);
    bus4.in_lb_x     = 12'(lbx);
    bus4.in_tm_base  = 10'(tmb);
    bus4.in_tb_base  = 14'(tbb);
  endtask

  task automatic applyRandom();
    applyStimulus(1'b1, $urandom_range(0, 2047), $urandom_range(0, 4095),
                  $urandom_range(0, 1023), $urandom_range(0, 16383));
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 60;
    applyStimulus(1'b0, 0, 0, 0, 0);
    bus4.out_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    checkOutput(tag, 64'(q.size()), 64'd0);
  endtask

  // Global time limit so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    exp_t e;
    logic [63:0] flip_pix;
    logic [13:0] flip_addr;

    for (int i = 0; i < 1024; i++)  tmap[i] = 16'($urandom);
    for (int i = 0; i < 16384; i++) tile[i] = 16'($urandom);
    tmap[1]      = 16'h0C05;
    tile[14'h00B] = 16'h1230;
    tmap[10'h101] = 16'h8005;
    tile[14'h10A] = 16'h5678;
    tile[14'h10B] = 16'h1234;
    tmap[0]      = 16'h0007;
    tile[14'h21C] = 16'hA500;

    applyStimulus(1'b0, 0, 0, 0, 0);
    bus4.out_ready   = 1'b1;
    bus8.in_valid    = 1'b0;
    bus8.in_sprite_x = '0;
    bus8.in_lb_x     = '0;
    bus8.in_tm_base  = '0;
    bus8.in_tb_base  = '0;
    bus8.out_ready   = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    checkOutput("rst_out_mask", 64'(bus4.out_mask), 64'd0);
    checkOutput("rst_out_pixels", 64'(bus4.out_pixels), 64'd0);
    checkOutput("rst_out_lb_x", 64'(bus4.out_lb_x), 64'd0);
    checkOutput("rst_tm_re", 64'(bus4.tm_re), 64'd0);
    checkOutput("rst_tb_re", 64'(bus4.tb_re), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("in_ready_after_reset", 64'(bus4.in_ready), 64'd1);
    checkOutput("tm_re_after_reset", 64'(bus4.tm_re), 64'd1);

    // Single request: addresses, exact 3-cycle latency, lane contents
    applyStimulus(1'b1, 3, 12'h055, 0, 0);
    #1 checkOutput("single_tm_addr", 64'(bus4.tm_addr), 64'h1);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("single_tb_addr", 64'(bus4.tb_addr), 64'h00B);
    checkOutput("single_lat1", 64'(bus4.out_valid), 64'd0);
    step();
    checkOutput("single_lat2", 64'(bus4.out_valid), 64'd0);
    step();
    e = model(4, 3, 12'h055, 0, 0);
    checkOutput("single_lat3", 64'(bus4.out_valid), 64'd1);
    checkOutput("single_mask", 64'(bus4.out_mask), 64'b0111);
    checkOutput("single_pixels", 64'(bus4.out_pixels), e.pix);
    checkOutput("single_lb_x", 64'(bus4.out_lb_x), 64'h055);
    step();

    // Horizontal flip case (tilemap entry 0x8005 at 0x101, tile base 0x100)
`ifdef TILE_HFLIP_EN
    flip_addr = 14'h10B;
    flip_pix  = 64'({9'h001, 9'h002, 9'h003, 9'h004});
`else
    flip_addr = 14'h10A;
    flip_pix  = 64'({9'h008, 9'h007, 9'h006, 9'h005});
`endif
    applyStimulus(1'b1, 2, 12'h0AA, 10'h100, 14'h100);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("flip_tb_addr", 64'(bus4.tb_addr), 64'(flip_addr));
    step();
    step();
    checkOutput("flip_valid", 64'(bus4.out_valid), 64'd1);
    checkOutput("flip_pixels", 64'(bus4.out_pixels), flip_pix);
    checkOutput("flip_mask", 64'(bus4.out_mask), 64'hF);
    step();

    // Eight back-to-back requests: full throughput, in order
    for (int c = 0; c < 13; c++) begin
      if (c < 8) applyRandom();
      else       applyStimulus(1'b0, 0, 0, 0, 0);
      #1 if (c < 8) checkOutput("stream_in_ready", 64'(bus4.in_ready), 64'd1);
      step();
      checkOutput("stream_out_valid", 64'(bus4.out_valid), 64'((c + 1 >= 3) && (c + 1 <= 10)));
    end
    drain("stream_drain");

    // Five stalled cycles in the middle of a stream
    for (int c = 0; c < 14; c++) begin
      bus4.out_ready = !(c >= 5 && c <= 9);
      if (c < 12) applyRandom();
      else        applyStimulus(1'b0, 0, 0, 0, 0);
      #1 checkOutput("stall_in_ready", 64'(bus4.in_ready), 64'(!(c >= 5 && c <= 9)));
      if (c >= 5 && c <= 9) checkOutput("stall_tm_re", 64'(bus4.tm_re), 64'd0);
      step();
    end
    drain("stall_drain");

    // Flush with three groups in flight and a fourth offered
    for (int c = 0; c < 3; c++) begin
      applyRandom();
      step();
    end
    bus4.out_ready = 1'b0;
    applyRandom();
    flush = 1'b1;
    #1 checkOutput("flush_in_ready", 64'(bus4.in_ready), 64'd0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    bus4.out_ready = 1'b1;
    checkOutput("flush_out_valid", 64'(bus4.out_valid), 64'd0);
    checkOutput("flush_out_mask", 64'(bus4.out_mask), 64'd0);
    repeat (6) begin
      step();
      checkOutput("flush_quiet", 64'(bus4.out_valid), 64'd0);
    end

    // Flush in the same cycle a request is accepted
    applyRandom();
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    repeat (5) begin
      step();
      checkOutput("flush_accept_quiet", 64'(bus4.out_valid), 64'd0);
    end

    // Reset in the middle of traffic
    for (int c = 0; c < 3; c++) begin
      applyRandom();
      step();
    end
    applyRandom();
    rst = 1'b1;
    step();
    checkOutput("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
    checkOutput("midrst_out_pixels", 64'(bus4.out_pixels), 64'd0);
    checkOutput("midrst_out_lb_x", 64'(bus4.out_lb_x), 64'd0);
    checkOutput("midrst_tb_re", 64'(bus4.tb_re), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    step();
    checkOutput("midrst_in_ready", 64'(bus4.in_ready), 64'd1);
    repeat (6) begin
      step();
      checkOutput("midrst_quiet", 64'(bus4.out_valid), 64'd0);
    end

    // Random traffic with random backpressure
    for (int c = 0; c < 120; c++) begin
      bus4.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) applyRandom();
      else                           applyStimulus(1'b0, 0, 0, 0, 0);
      step();
    end
    drain("random_drain");

    // 8bpp instance: tilemap address wraps, tile address uses {tile, 2'b00}
    bus8.in_valid    = 1'b1;
    bus8.in_sprite_x = 11'd4;
    bus8.in_lb_x     = 12'h123;
    bus8.in_tm_base  = 10'h3FF;
    bus8.in_tb_base  = 14'h200;
    #1 checkOutput("bpp8_tm_addr", 64'(bus8.tm_addr), 64'h000);
    step();
    bus8.in_valid = 1'b0;
    checkOutput("bpp8_tb_addr", 64'(bus8.tb_addr), 64'h21C);
    step();
    step();
    e = model(8, 4, 12'h123, 10'h3FF, 14'h200);
    checkOutput("bpp8_valid", 64'(bus8.out_valid), 64'd1);
    checkOutput("bpp8_pixels", 64'(bus8.out_pixels), e.pix);
    checkOutput("bpp8_mask", 64'(bus8.out_mask), 64'b01);
    checkOutput("bpp8_lb_x", 64'(bus8.out_lb_x), 64'h123);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
